// File: rtl/ula_pkg.sv
// Shared ULA definitions: divider FSM states, default width, counter width and
// the divide-by-zero quotient pattern.
package ula_pkg;

  localparam int N_PADRAO = 4;
  localparam int CNT_W    = $clog2(N_PADRAO) + 1;
  localparam logic [N_PADRAO-1:0] QUO_DIV_ZERO = '1;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    CALCULA = 2'd1,
    FIM     = 2'd2
  } estado_t;

endpackage

// File: rtl/subtrator_tentativa.sv
// Trial subtractor for the restoring divider: x + ~y + 1, carry-out means no borrow.
module subtrator_tentativa #(
  parameter int W = 5
) (
  input  logic [W-1:0] minuendo,
  input  logic [W-1:0] subtraendo,
  output logic [W-1:0] diferenca,
  output logic         sem_emprestimo
);

  always_comb begin
    {sem_emprestimo, diferenca} = {1'b0, minuendo} + {1'b0, ~subtraendo} + {{W{1'b0}}, 1'b1};
  end

endmodule

// File: rtl/divisor_sequencial_4bits.sv
// Sequential restoring divider, one quotient bit per clock, start/done handshake.
// Optional two's-complement operation when DIVISOR_SINAL_EN is defined.
module divisor_sequencial_4bits
  import ula_pkg::*;
#(
  parameter int N = N_PADRAO
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inicio,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] quociente,
  output logic [N-1:0] resto,
  output logic         pronto,
  output logic         ocupado,
  output logic         div_zero,
  output logic         ov
);

  localparam int CW = $clog2(N) + 1;
  typedef logic [N-1:0] palavra_t;
  typedef logic [N:0]   larga_t;

  estado_t         estado_q, estado_d;
  palavra_t        dvd_q, dvd_d, dvs_q, dvs_d, quo_q, quo_d;
  palavra_t        quociente_q, quociente_d, resto_q, resto_d;
  larga_t          rem_q, rem_d, rem_sh, rem_nx, dif;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            pronto_q, pronto_d, ocupado_q, ocupado_d, div_zero_q, div_zero_d;
  logic            sem_emprestimo, carrega, finaliza;
  palavra_t        quo_nx, a_op, b_op, q_fim, r_fim;

  subtrator_tentativa #(.W(N + 1)) u_sub (
    .minuendo       (rem_sh),
    .subtraendo     ({1'b0, dvs_q}),
    .diferenca      (dif),
    .sem_emprestimo (sem_emprestimo)
  );

  // Partial remainder stays N+1 wide; the cast drops its top bit as the dividend MSB enters.
  always_comb begin
    rem_sh   = larga_t'({rem_q, dvd_q[N-1]});
    rem_nx   = sem_emprestimo ? dif : rem_sh;
    quo_nx   = {quo_q[N-2:0], sem_emprestimo};
    carrega  = (estado_q != CALCULA) && inicio;
    finaliza = (estado_q == CALCULA) && (cnt_q == CW'(N - 1));
  end

`ifdef DIVISOR_SINAL_EN
  logic sinal_a_q, sinal_a_d, sinal_b_q, sinal_b_d, ov_pend_q, ov_pend_d, ov_q, ov_d;

  always_comb begin
    a_op      = a[N-1] ? palavra_t'(-a) : a;
    b_op      = b[N-1] ? palavra_t'(-b) : b;
    q_fim     = (sinal_a_q ^ sinal_b_q) ? palavra_t'(-quo_nx) : quo_nx;
    r_fim     = sinal_a_q ? palavra_t'(-palavra_t'(rem_nx)) : palavra_t'(rem_nx);
    sinal_a_d = sinal_a_q;
    sinal_b_d = sinal_b_q;
    ov_pend_d = ov_pend_q;
    ov_d      = ov_q;
    if (carrega) begin
      sinal_a_d = a[N-1];
      sinal_b_d = b[N-1];
      ov_pend_d = (a == {1'b1, {(N-1){1'b0}}}) && (b == '1);
      ov_d      = 1'b0;
    end
    if (finaliza) ov_d = ov_pend_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sinal_a_q <= 1'b0;
      sinal_b_q <= 1'b0;
      ov_pend_q <= 1'b0;
      ov_q      <= 1'b0;
    end else begin
      sinal_a_q <= sinal_a_d;
      sinal_b_q <= sinal_b_d;
      ov_pend_q <= ov_pend_d;
      ov_q      <= ov_d;
    end
  end

  assign ov = ov_q;
`else
  always_comb begin
    a_op  = a;
    b_op  = b;
    q_fim = quo_nx;
    r_fim = palavra_t'(rem_nx);
  end

  assign ov = 1'b0;
`endif

  always_comb begin
    estado_d    = estado_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    quociente_d = quociente_q;
    resto_d     = resto_q;
    pronto_d    = 1'b0;
    ocupado_d   = ocupado_q;
    div_zero_d  = div_zero_q;
    unique case (estado_q)
      OCIOSO, FIM: begin
        estado_d = OCIOSO;
        if (carrega) begin
          dvd_d = a_op;
          dvs_d = b_op;
          quo_d = '0;
          rem_d = '0;
          cnt_d = '0;
          if (b == '0) begin
            estado_d    = FIM;
            quociente_d = '1;
            resto_d     = a;
            div_zero_d  = 1'b1;
            pronto_d    = 1'b1;
            ocupado_d   = 1'b0;
          end else begin
            estado_d   = CALCULA;
            div_zero_d = 1'b0;
            ocupado_d  = 1'b1;
          end
        end
      end
      CALCULA: begin
        rem_d = rem_nx;
        dvd_d = dvd_q << 1;
        quo_d = quo_nx;
        cnt_d = cnt_q + CW'(1);
        if (finaliza) begin
          estado_d    = FIM;
          quociente_d = q_fim;
          resto_d     = r_fim;
          pronto_d    = 1'b1;
          ocupado_d   = 1'b0;
        end
      end
      default: estado_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q    <= OCIOSO;
      dvd_q       <= '0;
      dvs_q       <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      quociente_q <= '0;
      resto_q     <= '0;
      pronto_q    <= 1'b0;
      ocupado_q   <= 1'b0;
      div_zero_q  <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      quociente_q <= quociente_d;
      resto_q     <= resto_d;
      pronto_q    <= pronto_d;
      ocupado_q   <= ocupado_d;
      div_zero_q  <= div_zero_d;
    end
  end

  assign quociente = quociente_q;
  assign resto     = resto_q;
  assign pronto    = pronto_q;
  assign ocupado   = ocupado_q;
  assign div_zero  = div_zero_q;

endmodule

// File: doc/divisor_sequencial_4bits.md
Name: divisor_sequencial_4bits

Overview:
- Sequential unsigned restoring divider. It computes quotient and remainder of a / b by shift-and-subtract, one quotient bit per clock.
- It reuses the ULA's subtract path (B inverted, carry-in 1) as the trial subtractor.
- It is the inverse operation partner of the ULA multiplier/adder datapath and sits beside the adder/subtractor under the ULA operation mux.
- Start/done handshake to the ULA controller.

Parameters:
- N, 4, operand, quotient and remainder width in bits.

Ports:
- clk  input  1  single system clock, rising edge
- rst  input  1  reset, synchronous, active-high
- inicio  input  1  start request; sampled on rising edge
- a  input  N  dividend
- b  input  N  divisor
- quociente  output  N  quotient, registered
- resto  output  N  remainder, registered
- pronto  output  1  result-valid pulse, one cycle
- ocupado  output  1  high while a division is in progress
- div_zero  output  1  sticky flag for the last result: divisor was zero
- ov  output  1  signed-overflow flag (see Optional Feature); constant 0 when the feature is absent

Behaviour:
- Clock/reset:
  - One clock (clk); reset rst is synchronous and active-high.
  - On rst: state=OCIOSO; quociente=0, resto=0, pronto=0, ocupado=0, div_zero=0, ov=0; counter=0.
  - rst has priority over everything, including mid-division; a partial result is discarded.
- States: OCIOSO, CALCULA, FIM.
- OCIOSO or FIM with inicio=1 (edge k):
  - Latch a into the dividend shift register and b into the divisor register.
  - Clear the N+1-bit partial-remainder register.
  - Set counter=0, ocupado=1, pronto=0.
  - If b==0: go directly to FIM with quociente=all ones, resto=a, div_zero=1; pronto=1 in the cycle after edge k.
  - Else: go to CALCULA with div_zero=0.
- CALCULA, each edge:
  - Shift the partial remainder left one bit, inserting the dividend MSB; shift the dividend left.
  - Trial subtract: partial remainder (N+1 bits) minus zero-extended divisor.
  - No borrow (carry-out=1): keep the difference and shift quotient bit 1 in.
  - Borrow: restore (keep the shifted value) and shift quotient bit 0 in.
  - Increment counter.
- Completion:
  - At the edge where counter reaches N-1, register the final quociente/resto, go to FIM, set pronto=1, clear ocupado.
  - Latency: inicio sampled at edge k gives pronto high between edges k+N and k+N+1.
- FIM, for one cycle:
  - inicio=0 -> OCIOSO.
  - inicio=1 -> new operation accepted (back-to-back allowed).
  - pronto drops after one cycle either way.
- Output hold: quociente, resto, div_zero and ov hold their values until the next accepted inicio or rst.
- inicio in CALCULA is ignored: no restart and no queueing.
- a and b changing during CALCULA has no effect, since operands are latched.
- Arithmetic: unsigned; the partial remainder is N+1 bits so the trial subtraction never loses the MSB. The invariant a = quociente*b + resto with resto < b holds for every b != 0.

Optional Feature:
- Macro: DIVISOR_SINAL_EN.
- Defined — two's-complement operands:
  - At load, latch |a| and |b| and record the signs.
  - At the final register write, negate quociente if sign(a) xor sign(b); give resto the sign of a.
  - Latency is unchanged.
  - -2^(N-1) / -1 sets ov=1 with quociente=2^(N-1) bit pattern and resto=0.
  - Divide-by-zero behaves as above, with resto=a as given.
- Undefined: unsigned only; ov is tied 0; no sign logic is synthesized.

Decomposition:
- Shared package ula_pkg:
  - State enum (OCIOSO, CALCULA, FIM).
  - Default width constant N=4.
  - Counter width as $clog2(N)+1.
  - Divide-by-zero quotient constant (all ones).
- Natural sub-module: subtrator_tentativa — combinational (N+1)-bit subtractor (inverted B, carry-in 1) returning difference and no-borrow flag. It is instantiated once in the datapath.

Test Plan:
- rst, then inicio with a=13, b=3 -> pronto high exactly at edge k+4 window; quociente=4, resto=1, div_zero=0, ocupado low after.
- a=15, b=1, then back-to-back inicio in FIM with a=3, b=9 -> first 15/0, then 0/3, each with its own one-cycle pronto.
- a=7, b=0 -> pronto one cycle after start; quociente=4'hF, resto=7, div_zero=1; next valid division clears div_zero.
- Start a=14, b=5; pulse inicio again at k+2 with different operands -> ignored, result 2/4. Separately, rst at k+2 -> all outputs 0, state OCIOSO, no pronto.
- Exhaustive sweep: all a in 0..15, b in 1..15 -> a == quociente*b + resto and resto < b each time; pronto always at k+N.
- With DIVISOR_SINAL_EN:
  - -7/2 -> quociente=4'b1101 (-3), resto=4'b1111 (-1).
  - -8/-1 -> ov=1, quociente=4'b1000.
  - Without the macro, ov stays 0 throughout.
